// File: rtl/sparse_hls_deadlock_report_unit.sv
// Deadlock report collector: debounces unit flags, elects an origin, traces the token, latches a sticky report.
// Optional TRACE timeout abort is compiled in with SPARSE_HLS_DL_TIMEOUT_EN.
module sparse_hls_deadlock_report_unit #(
  parameter int PROC_NUM       = 4,
  parameter int PROC_ID_W      = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PROC_NUM-1:0]  dl_in_vec,
  input  logic                 deadlock_ack,
  output logic [PROC_NUM-1:0]  origin,
  output logic                 dl_detect_out,
  output logic                 token_clear,
  output logic                 deadlock_flag,
  output logic                 deadlock_valid,
  output logic [PROC_ID_W-1:0] deadlock_proc_id,
  output logic [CNT_W-1:0]     deadlock_count
);

  localparam int CONF_W = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ORIGIN, S_TRACE, S_REPORT, S_LOCKED, S_CLEAR
  } state_t;

  generate
    if (CONFIRM_CYCLES < 1 || TIMEOUT_CYCLES < 2 || PROC_ID_W < $clog2(PROC_NUM)) begin : g_bad_param
      $error("sparse_hls_deadlock_report_unit: illegal parameter combination");
    end
  endgenerate

  state_t               state;
  logic [CONF_W-1:0]    confirm_cnt;
  logic [PROC_ID_W-1:0] origin_idx;
  logic [PROC_ID_W-1:0] low_idx;
  logic                 any_dl;
  logic                 token_ret;
  logic                 tmo_hit;

  assign any_dl    = |dl_in_vec;
  assign token_ret = dl_in_vec[origin_idx];

  // Lowest requesting unit wins the election.
  always_comb begin
    low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (dl_in_vec[i]) low_idx = PROC_ID_W'(i);
  end

  assign token_clear = ((state == S_TRACE) && token_ret) || (state == S_CLEAR);

`ifdef SPARSE_HLS_DL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  tmo_cnt <= '0;
    else if (state == S_CLEAR)  tmo_cnt <= '0;
    else if (state == S_TRACE)  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = (state == S_TRACE) && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      confirm_cnt      <= '0;
      origin_idx       <= '0;
      origin           <= '0;
      dl_detect_out    <= 1'b0;
      deadlock_flag    <= 1'b0;
      deadlock_valid   <= 1'b0;
      deadlock_proc_id <= '0;
      deadlock_count   <= '0;
    end else begin
      origin         <= '0;
      deadlock_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!any_dl) begin
            confirm_cnt <= '0;
          end else if (confirm_cnt == CONF_LAST) begin
            origin_idx    <= low_idx;
            origin        <= PROC_NUM'(1) << low_idx;
            dl_detect_out <= 1'b1;
            state         <= S_ORIGIN;
          end else begin
            confirm_cnt <= confirm_cnt + CONF_W'(1);
          end
        end
        S_ORIGIN: state <= S_TRACE;
        S_TRACE: begin
          // Token return takes priority over a coincident timeout.
          if (token_ret) begin
            deadlock_valid   <= 1'b1;
            deadlock_flag    <= 1'b1;
            deadlock_proc_id <= origin_idx;
            if (deadlock_count != {CNT_W{1'b1}})
              deadlock_count <= deadlock_count + CNT_W'(1);
            state <= S_REPORT;
          end else if (tmo_hit) begin
            dl_detect_out <= 1'b0;
            state         <= S_CLEAR;
          end
        end
        S_REPORT: state <= S_LOCKED;
        S_LOCKED: begin
          if (deadlock_ack) begin
            deadlock_flag <= 1'b0;
            dl_detect_out <= 1'b0;
            state         <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          confirm_cnt <= '0;
          state       <= S_IDLE;
        end
        default: begin
          dl_detect_out <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_hls_deadlock_report_unit.sv
// Scoreboard bench: stimulus queues expected origin/report events, a monitor pops and checks them.
module tb_sparse_hls_deadlock_report_unit;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dl_in_vec;
  logic       deadlock_ack;
  logic [3:0] origin;
  logic       dl_detect_out, token_clear, deadlock_flag, deadlock_valid;
  logic [1:0] deadlock_proc_id;
  logic [7:0] deadlock_count;

  sparse_hls_deadlock_report_unit #(
    .PROC_NUM(4), .PROC_ID_W(2), .CONFIRM_CYCLES(4), .TIMEOUT_CYCLES(64), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .dl_in_vec(dl_in_vec), .deadlock_ack(deadlock_ack),
    .origin(origin), .dl_detect_out(dl_detect_out), .token_clear(token_clear),
    .deadlock_flag(deadlock_flag), .deadlock_valid(deadlock_valid),
    .deadlock_proc_id(deadlock_proc_id), .deadlock_count(deadlock_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] cnt;
  } rep_t;

  rep_t       rep_q[$];
  logic [3:0] org_q[$];
  int         total = 0;
  int         bad = 0;
  int         exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an origin pulse or a report.
  initial begin
    logic [3:0] eo;
    rep_t       er;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (origin != 4'b0) begin
          if (org_q.size() == 0) chk("origin_unexpected", 32'(origin), 32'h0);
          else begin
            eo = org_q.pop_front();
            chk("origin", 32'(origin), 32'(eo));
          end
        end
        if (deadlock_valid) begin
          if (rep_q.size() == 0) chk("report_unexpected", 32'(deadlock_valid), 32'h0);
          else begin
            er = rep_q.pop_front();
            chk("report_id", 32'(deadlock_proc_id), 32'(er.id));
            chk("report_count", 32'(deadlock_count), 32'(er.cnt));
            chk("report_flag", 32'(deadlock_flag), 32'h1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input logic [3:0] v);
    @(posedge clock); #1;
    dl_in_vec = v;
    @(negedge clock);
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // Called mid-cycle while LOCKED; ends mid-cycle in IDLE.
  task automatic ack_seq;
    @(posedge clock); #1;
    dl_in_vec = 4'b0; deadlock_ack = 1'b1;
    @(negedge clock);
    chk("locked_flag", 32'(deadlock_flag), 32'h1);
    @(posedge clock); #1;
    deadlock_ack = 1'b0;
    @(negedge clock);
    chk("clear_flag", 32'(deadlock_flag), 32'h0);
    chk("clear_token_clear", 32'(token_clear), 32'h1);
    chk("clear_detect", 32'(dl_detect_out), 32'h0);
    cyc(4'b0);
    chk("idle_token_clear", 32'(token_clear), 32'h0);
    chk("idle_detect", 32'(dl_detect_out), 32'h0);
  endtask

  task automatic run_detect(input logic [3:0] vec, input logic [3:0] org,
                            input logic [3:0] ret, input logic [1:0] id);
    org_q.push_back(org);
    repeat (4) cyc(vec);
    chk("pre_elect_detect", 32'(dl_detect_out), 32'h0);
    cyc(4'b0);
    chk("origin_detect", 32'(dl_detect_out), 32'h1);
    cyc(4'b0);
    chk("trace_origin_low", 32'(origin), 32'h0);
    chk("trace_token_clear_idle", 32'(token_clear), 32'h0);
    chk("trace_detect", 32'(dl_detect_out), 32'h1);
    exp_cnt = sat_inc(exp_cnt);
    rep_q.push_back({id, 8'(exp_cnt)});
    cyc(ret);
    chk("return_token_clear", 32'(token_clear), 32'h1);
    cyc(4'b0);
    chk("report_detect", 32'(dl_detect_out), 32'h1);
    cyc(4'b0);
    chk("locked_valid_low", 32'(deadlock_valid), 32'h0);
    chk("locked_id", 32'(deadlock_proc_id), 32'(id));
    chk("locked_count", 32'(deadlock_count), 32'(exp_cnt));
    ack_seq();
  endtask

  initial begin
    logic [1:0] p;
    logic [3:0] v;
    reset = 1'b1; dl_in_vec = 4'b0; deadlock_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_origin", 32'(origin), 32'h0);
    chk("rst_detect", 32'(dl_detect_out), 32'h0);
    chk("rst_token_clear", 32'(token_clear), 32'h0);
    chk("rst_flag", 32'(deadlock_flag), 32'h0);
    chk("rst_valid", 32'(deadlock_valid), 32'h0);
    chk("rst_id", 32'(deadlock_proc_id), 32'h0);
    chk("rst_count", 32'(deadlock_count), 32'h0);

    // T1/T2: 0110 elects process 1, token returns on bit 1.
    run_detect(4'b0110, 4'b0010, 4'b0010, 2'd1);

    // T3: interrupted run restarts the confirm counter; ack and foreign bits ignored in TRACE.
    repeat (3) cyc(4'b0100);
    cyc(4'b0);
    repeat (3) cyc(4'b1100);
    chk("t3_no_early_elect", 32'(dl_detect_out), 32'h0);
    org_q.push_back(4'b0100);
    cyc(4'b1100);
    cyc(4'b0);
    chk("t3_origin_detect", 32'(dl_detect_out), 32'h1);
    @(posedge clock); #1;
    dl_in_vec = 4'b0; deadlock_ack = 1'b1;
    @(negedge clock);
    chk("t3_trace_ack_ignored", 32'(token_clear), 32'h0);
    @(posedge clock); #1;
    deadlock_ack = 1'b0; dl_in_vec = 4'b1000;
    @(negedge clock);
    chk("t3_other_bit_ignored", 32'(token_clear), 32'h0);
    chk("t3_still_tracing", 32'(dl_detect_out), 32'h1);
    exp_cnt = sat_inc(exp_cnt);
    rep_q.push_back({2'd2, 8'(exp_cnt)});
    cyc(4'b0100);
    chk("t3_return_token_clear", 32'(token_clear), 32'h1);
    cyc(4'b0);
    cyc(4'b0);
    chk("t3_locked_flag", 32'(deadlock_flag), 32'h1);
    ack_seq();

    // T4: only a foreign bit in TRACE.
    org_q.push_back(4'b0001);
    repeat (4) cyc(4'b0001);
    cyc(4'b0);
`ifdef SPARSE_HLS_DL_TIMEOUT_EN
    for (int i = 0; i < 64; i++) begin
      cyc(4'b1000);
      chk("t4_trace_token_clear", 32'(token_clear), 32'h0);
      chk("t4_trace_detect", 32'(dl_detect_out), 32'h1);
    end
    cyc(4'b0);
    chk("t4_abort_token_clear", 32'(token_clear), 32'h1);
    chk("t4_abort_detect", 32'(dl_detect_out), 32'h0);
    chk("t4_abort_count", 32'(deadlock_count), 32'(exp_cnt));
    chk("t4_abort_flag", 32'(deadlock_flag), 32'h0);
    cyc(4'b0);
    chk("t4_idle_token_clear", 32'(token_clear), 32'h0);
    chk("t4_idle_detect", 32'(dl_detect_out), 32'h0);
`else
    for (int i = 0; i < 80; i++) begin
      cyc(4'b1000);
      chk("t4_trace_token_clear", 32'(token_clear), 32'h0);
      chk("t4_trace_detect", 32'(dl_detect_out), 32'h1);
    end
    exp_cnt = sat_inc(exp_cnt);
    rep_q.push_back({2'd0, 8'(exp_cnt)});
    cyc(4'b0001);
    chk("t4_return_token_clear", 32'(token_clear), 32'h1);
    cyc(4'b0);
    cyc(4'b0);
    ack_seq();
`endif

    // T5: repeated detect/ack cycles drive the count into saturation.
    for (int k = 0; k < 256; k++) begin
      p = 2'(k % 4);
      v = 4'b0001 << p;
      run_detect(v, v, v, p);
    end
    chk("t5_count_saturated", 32'(deadlock_count), 32'd255);

    // T6: asynchronous reset in the middle of TRACE.
    org_q.push_back(4'b0010);
    repeat (4) cyc(4'b0010);
    cyc(4'b0);
    cyc(4'b0);
    chk("t6_pre_reset_detect", 32'(dl_detect_out), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_origin", 32'(origin), 32'h0);
    chk("t6_rst_detect", 32'(dl_detect_out), 32'h0);
    chk("t6_rst_token_clear", 32'(token_clear), 32'h0);
    chk("t6_rst_flag", 32'(deadlock_flag), 32'h0);
    chk("t6_rst_valid", 32'(deadlock_valid), 32'h0);
    chk("t6_rst_id", 32'(deadlock_proc_id), 32'h0);
    chk("t6_rst_count", 32'(deadlock_count), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; dl_in_vec = 4'b0;
    @(negedge clock);
    chk("t6_idle_detect", 32'(dl_detect_out), 32'h0);
    chk("t6_idle_token_clear", 32'(token_clear), 32'h0);
    org_q.push_back(4'b0010);
    repeat (4) cyc(4'b0010);
    cyc(4'b0);
    chk("t6_reelect_detect", 32'(dl_detect_out), 32'h1);
    cyc(4'b0);

    chk("origin_queue_drained", 32'(org_q.size()), 32'h0);
    chk("report_queue_drained", 32'(rep_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
